data_mux_scan_sequencer: RTL

Controller that drives the `output_select` of the data mux so that each enabled input link is read out in turn. A scan is armed by software and aligned to the fast-control orbit sync. The sequencer holds each selected link for a programmed number of accepted output beats, then advances to the next enabled link. It sits beside the data mux in the `clk` domain and replaces static software selection during link-scan captures.

---
 rtl/data_mux_scan_sequencer_if.sv | 28 ++
 rtl/data_mux_scan_sequencer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/data_mux_scan_sequencer_if.sv
// Bundle of scan-control, fast-control and mux-side signals for the data mux scan sequencer.
// The sequencer connects through the slave modport; the controlling side uses master.
interface data_mux_scan_sequencer_if #(
    parameter int unsigned N_INPUTS = 16
);
    logic                start;
    logic [N_INPUTS-1:0] enable_mask;
    logic [15:0]         words_per_input;
    logic                fc_orbitSync;
    logic                fc_linkReset;
    logic                beat;
    logic [3:0]          output_select;
    logic                capture_window;
    logic                busy;
    logic                done;
    logic                aborted;
    logic [N_INPUTS-1:0] timeout_flags;

    modport master (
        output start, enable_mask, words_per_input, fc_orbitSync, fc_linkReset, beat,
        input  output_select, capture_window, busy, done, aborted, timeout_flags
    );

    modport slave (
        input  start, enable_mask, words_per_input, fc_orbitSync, fc_linkReset, beat,
        output output_select, capture_window, busy, done, aborted, timeout_flags
    );
endinterface

// File: rtl/data_mux_scan_sequencer.sv
// Steps the data mux output_select through each enabled input, orbit-aligned on the first one.
// Optional per-input idle-beat watchdog is compiled in with DATA_MUX_SEQ_TIMEOUT_EN.
module data_mux_scan_sequencer #(
    parameter int unsigned N_INPUTS       = 16,
    parameter int unsigned SETTLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input logic                        clk,
    input logic                        reset,
    data_mux_scan_sequencer_if.slave   seq
);

    typedef enum logic [1:0] {StIdle, StWaitSync, StSettle, StCapture} state_e;

    // The counter is loaded one short so SETTLE lasts exactly SETTLE_CYCLES cycles.
    localparam logic [7:0] SettleLoad = 8'(SETTLE_CYCLES - 1);

    state_e              state_q;
    logic [N_INPUTS-1:0] mask_q;
    logic [15:0]         words_q;
    logic [3:0]          sel_q;
    logic [7:0]          settle_cnt_q;
    logic [15:0]         beat_cnt_q;
    logic                cap_q;
    logic                busy_q;
    logic                done_q;
    logic                aborted_q;
    logic [N_INPUTS-1:0] tflags_q;

    logic [3:0] first_idx;
    logic       first_found;
    logic [3:0] next_idx;
    logic       next_found;
    logic       advance;
    logic       timeout_hit;

`ifdef DATA_MUX_SEQ_TIMEOUT_EN
    localparam logic [12:0] TimeoutLimit = 13'(TIMEOUT_CYCLES);
    logic [12:0] idle_cnt_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

    // Descending scan so the lowest qualifying index is the one left standing.
    always_comb begin
        first_idx   = '0;
        first_found = 1'b0;
        next_idx    = '0;
        next_found  = 1'b0;
        for (int i = int'(N_INPUTS) - 1; i >= 0; i--) begin
            if (seq.enable_mask[i]) begin
                first_idx   = 4'(i);
                first_found = 1'b1;
            end
            if (mask_q[i] && (4'(i) > sel_q)) begin
                next_idx   = 4'(i);
                next_found = 1'b1;
            end
        end
    end

    always_comb begin
        advance     = 1'b0;
        timeout_hit = 1'b0;
        case (state_q)
            StSettle:  advance = (settle_cnt_q == 8'd0) && (words_q == 16'd0);
            StCapture: begin
`ifdef DATA_MUX_SEQ_TIMEOUT_EN
                timeout_hit = !seq.beat && ((idle_cnt_q + 13'd1) == TimeoutLimit);
`endif
                advance = (seq.beat && ((beat_cnt_q + 16'd1) == words_q)) || timeout_hit;
            end
            default:   advance = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            mask_q       <= '0;
            words_q      <= '0;
            sel_q        <= '0;
            settle_cnt_q <= '0;
            beat_cnt_q   <= '0;
            cap_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            tflags_q     <= '0;
`ifdef DATA_MUX_SEQ_TIMEOUT_EN
            idle_cnt_q   <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (seq.start) begin
                        aborted_q <= 1'b0;
                        tflags_q  <= '0;
                        if (first_found) begin
                            mask_q  <= seq.enable_mask;
                            words_q <= seq.words_per_input;
                            sel_q   <= first_idx;
                            busy_q  <= 1'b1;
                            state_q <= StWaitSync;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                StWaitSync: begin
                    if (seq.fc_orbitSync) begin
                        settle_cnt_q <= SettleLoad;
                        state_q      <= StSettle;
                    end
                end
                StSettle: begin
                    if (settle_cnt_q != 8'd0) begin
                        settle_cnt_q <= settle_cnt_q - 8'd1;
                    end else if (words_q != 16'd0) begin
                        beat_cnt_q <= '0;
                        cap_q      <= 1'b1;
                        state_q    <= StCapture;
`ifdef DATA_MUX_SEQ_TIMEOUT_EN
                        idle_cnt_q <= '0;
`endif
                    end
                end
                StCapture: begin
                    if (seq.beat) begin
                        beat_cnt_q <= beat_cnt_q + 16'd1;
                    end
`ifdef DATA_MUX_SEQ_TIMEOUT_EN
                    idle_cnt_q <= seq.beat ? 13'd0 : idle_cnt_q + 13'd1;
                    if (timeout_hit) begin
                        tflags_q[sel_q] <= 1'b1;
                    end
`endif
                end
                default: state_q <= StIdle;
            endcase

            if (advance) begin
                cap_q <= 1'b0;
                if (next_found) begin
                    sel_q        <= next_idx;
                    settle_cnt_q <= SettleLoad;
                    state_q      <= StSettle;
                end else begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= StIdle;
                end
            end

            // Link reset overrides any same-cycle completion.
            if (seq.fc_linkReset && (state_q != StIdle)) begin
                state_q   <= StIdle;
                cap_q     <= 1'b0;
                busy_q    <= 1'b0;
                done_q    <= 1'b0;
                aborted_q <= 1'b1;
            end
        end
    end

    assign seq.output_select  = sel_q;
    assign seq.capture_window = cap_q;
    assign seq.busy           = busy_q;
    assign seq.done           = done_q;
    assign seq.aborted        = aborted_q;
`ifdef DATA_MUX_SEQ_TIMEOUT_EN
    assign seq.timeout_flags  = tflags_q;
`else
    assign seq.timeout_flags  = '0;
    logic unused_tflags;
    assign unused_tflags = ^tflags_q;
`endif

endmodule
